// File: rtl/cfi_sstack_checker.sv
// cfi_sstack_checker: shadow-stack consumer for the CFI log queue.
// Pops one control-flow log per cycle into stage 1, evaluates it in stage 2
// against a circular hardware shadow stack of return addresses, and raises a
// sticky fault (mismatch / underflow / overflow) that halts popping until
// software clears it.
// Optional build macro: CFI_SSTACK_OVF_FAULT_EN -- when defined, a call on a
// full stack faults with cause 3 instead of overwriting the oldest entry.
module cfi_sstack_checker #(
    parameter int SSTACK_DEPTH = 16,
    parameter int ADDR_WIDTH   = 64
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          queue_empty_i,
    output logic                          queue_pop_o,
    input  logic [ADDR_WIDTH-1:0]         log_pc_i,
    input  logic [ADDR_WIDTH-1:0]         log_target_i,
    input  logic                          log_call_i,
    input  logic                          log_ret_i,
    input  logic                          log_rvc_i,
    input  logic                          flush_i,
    input  logic                          fault_clear_i,
    output logic                          fault_o,
    output logic [1:0]                    fault_cause_o,
    output logic [ADDR_WIDTH-1:0]         fault_pc_o,
    output logic [$clog2(SSTACK_DEPTH):0] sstack_level_o
);

    localparam int PTR_W = $clog2(SSTACK_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    localparam logic [1:0] CAUSE_MISMATCH  = 2'd1;
    localparam logic [1:0] CAUSE_UNDERFLOW = 2'd2;
`ifdef CFI_SSTACK_OVF_FAULT_EN
    localparam logic [1:0] CAUSE_OVERFLOW  = 2'd3;
`endif

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FAULT = 1'b1
    } state_t;

    state_t                r_state;

    // Stage-1 register: the log entry popped last cycle
    logic                  r_s1_valid;
    logic [ADDR_WIDTH-1:0] r_s1_pc;
    logic [ADDR_WIDTH-1:0] r_s1_target;
    logic                  r_s1_call;
    logic                  r_s1_ret;
    logic                  r_s1_rvc;

    // Shadow stack: r_ptr is the next free slot, top of stack is r_ptr-1
    logic [ADDR_WIDTH-1:0] r_stack [SSTACK_DEPTH];
    logic [PTR_W-1:0]      r_ptr;
    logic [LVL_W-1:0]      r_level;

    logic                  r_fault;
    logic [1:0]            r_fault_cause;
    logic [ADDR_WIDTH-1:0] r_fault_pc;

    logic                  w_pop;
    logic                  w_eval;
    logic [PTR_W-1:0]      w_top_ptr;
    logic [ADDR_WIDTH-1:0] w_top;
    logic [ADDR_WIDTH-1:0] w_ret_addr;
    logic                  w_ret_ok;
    logic                  w_fault_set;
    logic [1:0]            w_fault_cause;
    logic                  w_wr_en;
    logic [PTR_W-1:0]      w_wr_addr;
    logic [PTR_W-1:0]      w_ptr_next;
    logic [LVL_W-1:0]      w_level_next;

    // Pop whenever running, data is available and no flush is discarding the stage
    assign w_pop       = (r_state == ST_RUN) && !queue_empty_i && !flush_i;
    assign queue_pop_o = w_pop && !rst_i;

    assign fault_o        = r_fault;
    assign fault_cause_o  = r_fault_cause;
    assign fault_pc_o     = r_fault_pc;
    assign sstack_level_o = r_level;

    // Stage-2 evaluation of the stage-1 entry against the top of stack
    always_comb begin
        w_eval        = r_s1_valid && (r_state == ST_RUN) && !flush_i;
        w_top_ptr     = r_ptr - PTR_W'(1);
        w_top         = r_stack[w_top_ptr];
        w_ret_addr    = r_s1_pc + (r_s1_rvc ? ADDR_WIDTH'(2) : ADDR_WIDTH'(4));
        w_ret_ok      = 1'b0;
        w_fault_set   = 1'b0;
        w_fault_cause = 2'd0;
        w_wr_en       = 1'b0;
        w_wr_addr     = r_ptr;
        w_ptr_next    = r_ptr;
        w_level_next  = r_level;
        if (w_eval) begin
            if (r_s1_ret) begin
                if (r_level == '0) begin
                    w_fault_set   = 1'b1;
                    w_fault_cause = CAUSE_UNDERFLOW;
                end else if (r_s1_target != w_top) begin
                    w_fault_set   = 1'b1;
                    w_fault_cause = CAUSE_MISMATCH;
                end else begin
                    w_ret_ok = 1'b1;
                end
            end
            if (r_s1_call && (!r_s1_ret || w_ret_ok)) begin
                if (w_ret_ok) begin
                    // Coroutine swap: pop then push collapses to replacing the top
                    w_wr_en   = 1'b1;
                    w_wr_addr = w_top_ptr;
                end else if (r_level == LVL_W'(SSTACK_DEPTH)) begin
`ifdef CFI_SSTACK_OVF_FAULT_EN
                    w_fault_set   = 1'b1;
                    w_fault_cause = CAUSE_OVERFLOW;
`else
                    // Full: overwrite the oldest entry, occupancy stays saturated
                    w_wr_en    = 1'b1;
                    w_ptr_next = r_ptr + PTR_W'(1);
`endif
                end else begin
                    w_wr_en      = 1'b1;
                    w_ptr_next   = r_ptr + PTR_W'(1);
                    w_level_next = r_level + LVL_W'(1);
                end
            end else if (w_ret_ok) begin
                w_ptr_next   = w_top_ptr;
                w_level_next = r_level - LVL_W'(1);
            end
        end
    end

    // Shadow-stack storage write; contents need no reset since level gates every read
    always_ff @(posedge clk_i) begin
        if (w_wr_en) begin
            r_stack[w_wr_addr] <= w_ret_addr;
        end
    end

    // Stage-1 capture, stack pointer/level update and RUN/FAULT state machine
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state       <= ST_RUN;
            r_s1_valid    <= 1'b0;
            r_s1_pc       <= '0;
            r_s1_target   <= '0;
            r_s1_call     <= 1'b0;
            r_s1_ret      <= 1'b0;
            r_s1_rvc      <= 1'b0;
            r_ptr         <= '0;
            r_level       <= '0;
            r_fault       <= 1'b0;
            r_fault_cause <= 2'd0;
            r_fault_pc    <= '0;
        end else begin
            // In FAULT the stage-1 entry is frozen so it can be evaluated after clear
            if (flush_i) begin
                r_s1_valid <= 1'b0;
            end else if (r_state == ST_RUN) begin
                r_s1_valid <= w_pop;
                if (w_pop) begin
                    r_s1_pc     <= log_pc_i;
                    r_s1_target <= log_target_i;
                    r_s1_call   <= log_call_i;
                    r_s1_ret    <= log_ret_i;
                    r_s1_rvc    <= log_rvc_i;
                end
            end

            if (flush_i) begin
                r_ptr   <= '0;
                r_level <= '0;
            end else begin
                r_ptr   <= w_ptr_next;
                r_level <= w_level_next;
            end

            case (r_state)
                ST_RUN: begin
                    if (w_fault_set) begin
                        r_state       <= ST_FAULT;
                        r_fault       <= 1'b1;
                        r_fault_cause <= w_fault_cause;
                        r_fault_pc    <= r_s1_pc;
                    end
                end
                ST_FAULT: begin
                    if (fault_clear_i) begin
                        r_state       <= ST_RUN;
                        r_fault       <= 1'b0;
                        r_fault_cause <= 2'd0;
                        r_fault_pc    <= '0;
                    end
                end
                default: r_state <= ST_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_cfi_sstack_checker.sv
// Testbench for cfi_sstack_checker: a transaction-level shadow-stack model
// predicts each popped log's outcome; the prediction is queued at pop time and
// compared when the DUT registers the stage-2 result.
module tb_cfi_sstack_checker;

    localparam int DEPTH = 16;
    localparam int AW    = 64;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          queue_empty_i;
    logic          queue_pop_o;
    logic [AW-1:0] log_pc_i;
    logic [AW-1:0] log_target_i;
    logic          log_call_i;
    logic          log_ret_i;
    logic          log_rvc_i;
    logic          flush_i;
    logic          fault_clear_i;
    logic          fault_o;
    logic [1:0]    fault_cause_o;
    logic [AW-1:0] fault_pc_o;
    logic [LW-1:0] sstack_level_o;

    always #5 clk_i = ~clk_i;

    cfi_sstack_checker #(.SSTACK_DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .queue_empty_i  (queue_empty_i),
        .queue_pop_o    (queue_pop_o),
        .log_pc_i       (log_pc_i),
        .log_target_i   (log_target_i),
        .log_call_i     (log_call_i),
        .log_ret_i      (log_ret_i),
        .log_rvc_i      (log_rvc_i),
        .flush_i        (flush_i),
        .fault_clear_i  (fault_clear_i),
        .fault_o        (fault_o),
        .fault_cause_o  (fault_cause_o),
        .fault_pc_o     (fault_pc_o),
        .sstack_level_o (sstack_level_o)
    );

    typedef struct {
        logic [AW-1:0] pc;
        logic [AW-1:0] tgt;
        bit            call;
        bit            ret;
        bit            rvc;
    } ent_t;

    typedef struct {
        int            due;
        bit            deferred;
        bit            f;
        logic [1:0]    cause;
        logic [AW-1:0] fpc;
        int            level;
        logic [AW-1:0] tpc;
    } exp_t;

    ent_t          src_q[$];
    exp_t          exp_q[$];
    logic [AW-1:0] m_stack[$];
    bit            m_fault = 0;
    int            errors  = 0;
    int            checks  = 0;
    int            cyc     = 0;
    ent_t          z_ent   = '{pc: '0, tgt: '0, call: 0, ret: 0, rvc: 0};

    function automatic ent_t mk(input logic [AW-1:0] pc, input logic [AW-1:0] tgt,
                                input bit call, input bit ret, input bit rvc);
        ent_t e;
        e.pc = pc; e.tgt = tgt; e.call = call; e.ret = ret; e.rvc = rvc;
        return e;
    endfunction

    // Behavioural shadow stack: queue back is the top, front is the oldest
    function automatic void model_eval(input ent_t e, output bit f, output logic [1:0] cause);
        bit            ok;
        logic [AW-1:0] ra;
        f = 0; cause = 2'd0; ok = 0;
        ra = e.pc + (e.rvc ? 64'd2 : 64'd4);
        if (e.ret) begin
            if (m_stack.size() == 0) begin f = 1; cause = 2'd2; end
            else if (e.tgt != m_stack[m_stack.size()-1]) begin f = 1; cause = 2'd1; end
            else ok = 1;
        end
        if (e.call && !f) begin
            if (ok) m_stack[m_stack.size()-1] = ra;
            else if (m_stack.size() == DEPTH) begin
`ifdef CFI_SSTACK_OVF_FAULT_EN
                f = 1; cause = 2'd3;
`else
                void'(m_stack.pop_front());
                m_stack.push_back(ra);
`endif
            end else m_stack.push_back(ra);
        end else if (ok) begin
            void'(m_stack.pop_back());
        end
    endfunction

    function automatic void schedule(input ent_t e);
        exp_t       r;
        bit         f;
        logic [1:0] c;
        model_eval(e, f, c);
        r.due      = cyc + 2;
        r.deferred = m_fault;
        r.f        = f;
        r.cause    = c;
        r.fpc      = f ? e.pc : '0;
        r.level    = m_stack.size();
        r.tpc      = e.pc;
        exp_q.push_back(r);
        if (f) m_fault = 1;
    endfunction

    // One clock: drive at negedge, note a pop, return 1ns after the posedge
    task automatic cycle(input bit have, input ent_t e, input bit flush, input bit clr,
                         output bit popped);
        @(negedge clk_i);
        queue_empty_i = !have;
        log_pc_i      = e.pc;
        log_target_i  = e.tgt;
        log_call_i    = e.call;
        log_ret_i     = e.ret;
        log_rvc_i     = e.rvc;
        flush_i       = flush;
        fault_clear_i = clr;
        #1;
        popped = queue_pop_o;
        if (popped) schedule(e);
        if (flush) m_stack.delete();
        if (clr && m_fault) begin
            foreach (exp_q[i]) begin
                if (exp_q[i].deferred) begin
                    exp_q[i].deferred = 0;
                    exp_q[i].due      = cyc + 2;
                end
            end
            m_fault = 0;
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle(input int n);
        bit p;
        for (int i = 0; i < n; i++) cycle(0, z_ent, 0, 0, p);
    endtask

    task automatic send_list();
        bit p;
        int budget = 0;
        while (src_q.size() > 0 && budget < 200) begin
            cycle(1, src_q[0], 0, 0, p);
            if (p) void'(src_q.pop_front());
            budget++;
        end
        checks++;
        if (src_q.size() != 0) begin
            errors++;
            $display("FAIL send_list: %0d entries never popped", src_q.size());
            src_q.delete();
        end
    endtask

    task automatic wait_fault();
        for (int k = 0; k < 10 && fault_o !== 1'b1; k++) idle(1);
        checks++;
        if (fault_o !== 1'b1) begin
            errors++;
            $display("FAIL wait_fault: fault_o=%b required 1 within 10 cycles", fault_o);
        end
    endtask

    task automatic clear_fault(input int exp_level);
        bit p;
        cycle(0, z_ent, 0, 1, p);
        checks++;
        if (fault_o !== 1'b0 || fault_cause_o !== 2'd0 || fault_pc_o !== '0 ||
            sstack_level_o !== LW'(exp_level)) begin
            errors++;
            $display("FAIL clear: fault=%b cause=%0d pc=%h level=%0d required 0/0/0/%0d",
                     fault_o, fault_cause_o, fault_pc_o, sstack_level_o, exp_level);
        end
    endtask

    task automatic check_level(input string name, input int lvl);
        checks++;
        if (sstack_level_o !== LW'(lvl)) begin
            errors++;
            $display("FAIL %s: level=%0d required %0d", name, sstack_level_o, lvl);
        end
    endtask

    task automatic check_all_zero(input string name);
        checks++;
        if (fault_o !== 1'b0 || fault_cause_o !== 2'd0 || fault_pc_o !== '0 ||
            sstack_level_o !== '0 || queue_pop_o !== 1'b0) begin
            errors++;
            $display("FAIL %s: fault=%b cause=%0d pc=%h level=%0d pop=%b required all 0",
                     name, fault_o, fault_cause_o, fault_pc_o, sstack_level_o, queue_pop_o);
        end
    endtask

    // Scoreboard: compare each prediction on the edge its stage-2 result lands
    always @(posedge clk_i) begin : mon
        exp_t r;
        cyc = cyc + 1;
        #1;
        while (exp_q.size() > 0 && !exp_q[0].deferred && exp_q[0].due <= cyc) begin
            r = exp_q.pop_front();
            checks++;
            if (r.due != cyc || fault_o !== r.f || fault_cause_o !== r.cause ||
                fault_pc_o !== r.fpc || sstack_level_o !== LW'(r.level)) begin
                errors++;
                $display("FAIL txn pc=%h: level=%0d fault=%b cause=%0d fpc=%h required level=%0d fault=%b cause=%0d fpc=%h (due %0d now %0d)",
                         r.tpc, sstack_level_o, fault_o, fault_cause_o, fault_pc_o,
                         r.level, r.f, r.cause, r.fpc, r.due, cyc);
            end else begin
                $display("txn pc=%h level=%0d fault=%b cause=%0d", r.tpc, r.level, r.f, r.cause);
            end
        end
    end

    task automatic apply_reset();
        @(negedge clk_i);
        rst_i         = 1'b1;
        queue_empty_i = 1'b0;
        exp_q.delete(); src_q.delete(); m_stack.delete(); m_fault = 0;
        #1;
        check_all_zero("reset_assert");
        @(negedge clk_i);
        rst_i         = 1'b0;
        queue_empty_i = 1'b1;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; queue_empty_i = 1'b0; flush_i = 0; fault_clear_i = 0;
        log_pc_i = '0; log_target_i = '0; log_call_i = 0; log_ret_i = 0; log_rvc_i = 0;
        #1;
        check_all_zero("reset_initial");
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0; queue_empty_i = 1'b1;
        idle(1);
        check_all_zero("reset_release");
    endtask

    task automatic test_call_ret();
        src_q.push_back(mk(64'h1000, 64'h0, 1, 0, 0));
        src_q.push_back(mk(64'h1010, 64'h1004, 0, 1, 0));
        send_list();
        idle(2);
        check_level("call_ret_final", 0);
    endtask

    task automatic test_mismatch();
        bit p;
        src_q.push_back(mk(64'h2000, 64'h0, 1, 0, 1));
        src_q.push_back(mk(64'h2100, 64'h2008, 0, 1, 0));
        src_q.push_back(mk(64'h2200, 64'h0, 0, 0, 0));
        send_list();
        wait_fault();
        for (int i = 0; i < 3; i++) begin
            cycle(1, mk(64'h2300, 64'h2002, 0, 1, 0), 0, 0, p);
            checks++;
            if (p !== 1'b0 || fault_o !== 1'b1 || fault_cause_o !== 2'd1 || fault_pc_o !== 64'h2100) begin
                errors++;
                $display("FAIL fault_hold: pop=%b fault=%b cause=%0d pc=%h required 0/1/1/2100",
                         p, fault_o, fault_cause_o, fault_pc_o);
            end
        end
        clear_fault(1);
        idle(2);
        check_level("mismatch_after_clear", 1);
        src_q.push_back(mk(64'h2300, 64'h2002, 0, 1, 0));
        send_list();
        idle(2);
    endtask

    task automatic test_underflow();
        apply_reset();
        src_q.push_back(mk(64'h3000, 64'h3000, 0, 1, 0));
        send_list();
        wait_fault();
        clear_fault(0);
        idle(1);
    endtask

    task automatic test_overflow();
        apply_reset();
        for (int i = 0; i <= DEPTH; i++) src_q.push_back(mk(64'h100 + 64'(4 * i), 64'h0, 1, 0, 0));
        send_list();
        idle(2);
        check_level("overflow_saturate", DEPTH);
`ifdef CFI_SSTACK_OVF_FAULT_EN
        wait_fault();
        clear_fault(DEPTH);
        for (int i = DEPTH - 1; i >= 0; i--)
            src_q.push_back(mk(64'h400 + 64'(4 * i), 64'h104 + 64'(4 * i), 0, 1, 0));
`else
        for (int i = DEPTH; i >= 1; i--)
            src_q.push_back(mk(64'h400 + 64'(4 * i), 64'h104 + 64'(4 * i), 0, 1, 0));
`endif
        send_list();
        idle(2);
        check_level("overflow_drained", 0);
        src_q.push_back(mk(64'h500, 64'h104, 0, 1, 0));
        send_list();
        wait_fault();
        clear_fault(0);
        idle(1);
    endtask

    task automatic test_flush();
        bit p;
        apply_reset();
        for (int i = 0; i < 3; i++) src_q.push_back(mk(64'h900 + 64'(4 * i), 64'h0, 1, 0, 0));
        send_list();
        idle(2);
        check_level("flush_pre", 3);
        cycle(1, mk(64'hA00, 64'h90C, 0, 1, 0), 1, 0, p);
        checks++;
        if (p !== 1'b0 || sstack_level_o !== '0) begin
            errors++;
            $display("FAIL flush: pop=%b level=%0d required pop=0 level=0", p, sstack_level_o);
        end
        src_q.push_back(mk(64'hA00, 64'h90C, 0, 1, 0));
        send_list();
        wait_fault();
        clear_fault(0);
        idle(1);
    endtask

    task automatic test_coroutine();
        src_q.push_back(mk(64'hB00, 64'h0, 1, 0, 0));
        src_q.push_back(mk(64'hC00, 64'hB04, 1, 1, 1));
        src_q.push_back(mk(64'hD00, 64'hC02, 0, 1, 0));
        src_q.push_back(mk(64'hD10, 64'h0, 0, 0, 0));
        send_list();
        idle(2);
        check_level("coroutine_final", 0);
    endtask

    task automatic test_back_to_back_reset();
        bit p;
        for (int i = 0; i < 3; i++) src_q.push_back(mk(64'h500 + 64'(4 * i), 64'h0, 1, 0, 0));
        src_q.push_back(mk(64'h600, 64'hDEAD, 0, 1, 0));
        src_q.push_back(mk(64'h700, 64'h0, 1, 0, 0));
        send_list();
        wait_fault();
        cycle(1, mk(64'h710, 64'h0, 1, 0, 0), 0, 0, p);
        #2;
        rst_i = 1'b1;
        exp_q.delete(); m_stack.delete(); m_fault = 0;
        #1;
        check_all_zero("reset_midop");
        @(negedge clk_i);
        rst_i = 1'b0; queue_empty_i = 1'b1;
        src_q.push_back(mk(64'h800, 64'h0, 1, 0, 0));
        src_q.push_back(mk(64'h810, 64'h804, 0, 1, 0));
        send_list();
        idle(2);
        check_level("after_reset_resume", 0);
    endtask

    initial begin
        test_reset();
        test_call_ret();
        test_mismatch();
        test_underflow();
        test_overflow();
        test_flush();
        test_coroutine();
        test_back_to_back_reset();
        idle(3);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d predictions never compared", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cfi_sstack_checker.md
Name: cfi_sstack_checker

Overview:
- Consumer stage behind the CFI log queue.
- Pops control-flow logs one per cycle and maintains a hardware shadow stack of return addresses: calls push, returns are compared against the top entry.
- A mismatch or underflow raises a sticky violation that halts further popping until software clears it.
- Sits between the CFI log queue and the CSR/exception logic.

Parameters:
- SSTACK_DEPTH, 16, number of shadow-stack entries; power of two, >= 2.
- ADDR_WIDTH, 64, width of PC and target fields (riscv::VLEN).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- queue_empty_i  in  1  log queue empty; head data valid when 0
- queue_pop_o  out  1  pop head of log queue this cycle
- log_pc_i  in  ADDR_WIDTH  PC of head log entry
- log_target_i  in  ADDR_WIDTH  resolved target of head log entry
- log_call_i  in  1  head entry is a call
- log_ret_i  in  1  head entry is a return
- log_rvc_i  in  1  head entry is a compressed instruction
- flush_i  in  1  discard shadow stack and in-flight entry (context switch)
- fault_clear_i  in  1  acknowledge and clear violation
- fault_o  out  1  sticky violation flag
- fault_cause_o  out  2  0=none, 1=ret mismatch, 2=underflow, 3=overflow
- fault_pc_o  out  ADDR_WIDTH  PC of offending instruction
- sstack_level_o  out  $clog2(SSTACK_DEPTH)+1  current occupancy

Behaviour:
- Reset, asynchronous on rst_i=1: all outputs 0, stack level 0, pointer 0, stage-1 valid 0, FSM RUN. Reset mid-operation discards everything in flight.
- FSM states: RUN, FAULT.
- Two-stage pipeline:
  - S1: in RUN, queue_pop_o = !queue_empty_i && !flush_i. The popped fields are registered into S1 with s1_valid=1; otherwise s1_valid=0.
  - S2: evaluates the S1 register combinationally and updates the stack at the clock edge. Sustained throughput is 1 entry/cycle.
- Evaluation of a valid S1 entry:
  - Call: push ret = pc + (rvc ? 2 : 4), truncated mod 2^ADDR_WIDTH. Pointer increments mod SSTACK_DEPTH; level saturates at SSTACK_DEPTH.
  - Call with level==SSTACK_DEPTH: overwrite the oldest entry (circular wrap), level stays at SSTACK_DEPTH, no fault.
  - Return with level==0: underflow; fault, cause 2.
  - Return with level>0: compare target with top.
    - Equal: pop, pointer decrements mod depth, level-1.
    - Unequal: fault, cause 1; the stack is not popped.
  - Both call and ret set (coroutine swap): evaluate as ret first, then push if ret passed, net level unchanged.
  - Neither set: no stack effect.
- Fault entry: registered. fault_o, fault_cause_o and fault_pc_o are valid the cycle after S2 evaluation; FSM moves to FAULT.
- In FAULT:
  - queue_pop_o=0.
  - An S1 entry popped in the same cycle as the faulting evaluation is held, not evaluated, until the fault is cleared.
  - Outputs hold their values.
- fault_clear_i in FAULT: next cycle fault_o=0, cause=0, pc=0, FSM to RUN. The stack is preserved and the held S1 entry is evaluated. fault_clear_i in RUN is ignored.
- flush_i: next cycle level=0, pointer=0, s1_valid=0, no pop in the flush cycle. Fault state is unaffected. flush_i wins over a same-cycle push/pop evaluation.
- fault_clear_i and flush_i in the same cycle: both take effect.
- sstack_level_o is registered; it reflects the post-update level.

Optional Feature:
- Macro CFI_SSTACK_OVF_FAULT_EN.
- Defined: a call with level==SSTACK_DEPTH does not push; fault with cause 3 and fault_pc_o = call PC.
- Undefined: circular overwrite as above; cause 3 is never produced.

Test Plan:
- Call at pc 0x1000 (rvc=0), then ret with target 0x1004 -> pops on consecutive cycles, level 1 then 0, fault_o stays 0.
- Call at pc 0x2000 (rvc=1), then ret with target 0x2008 -> fault_o=1, cause=1, fault_pc_o = ret PC; queue_pop_o=0 until fault_clear_i; level stays 1 after clear.
- Ret from reset state, target 0x3000 -> fault_o=1, cause=2 two cycles after pop.
- SSTACK_DEPTH+1 calls at pcs 0x100, 0x104, …, then DEPTH rets matching in reverse order -> no fault without the macro, level saturates at 16. Extra ret -> cause 2. With CFI_SSTACK_OVF_FAULT_EN: the 17th call gives cause 3.
- flush_i asserted with 3 entries stacked and queue non-empty -> no pop that cycle, level=0 next cycle; subsequent ret gives cause 2.
- rst_i pulsed during back-to-back pops with fault pending -> all outputs 0 immediately, FSM RUN, popping resumes after reset release.
